// File: rtl/decode_pkg.sv
// Shared types, constants and helpers for the ARMv7-subset decode stage.
//   alu_op_t     - 3-bit operation code sent to execute
//   op_t         - major opcode class in instruction bits [27:26]
//   CMD_*        - data-processing command encodings (instruction bits [24:21])
//   issue_pkt_t  - width-independent part of the registered issue packet
//   expand_imm() - ARM modified-immediate expansion (imm8 ROR 2*rot4)
package decode_pkg;

  // Widest datapath the helper below can expand into.
  localparam int MAX_DATA_WIDTH = 64;
  // Architectural index of the program counter.
  localparam int PC_REG = 15;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_ORR = 3'd3,
    ALU_MOV = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10
  } op_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  // Operand and destination widths depend on the stage parameters, so those
  // registers live beside this struct in the stage itself.
  typedef struct packed {
    logic       valid;
    alu_op_t    alu_op;
    logic [3:0] cond;
    logic       set_flags;
    logic       reg_write_en;
    logic       mem_write_en;
    logic       mem_to_reg;
    logic       branch;
  } issue_pkt_t;

  // Rotate the zero-extended imm8 right by 2*rot4 inside a 'width'-bit word.
  // The result is returned in MAX_DATA_WIDTH bits with everything above
  // 'width' cleared; callers truncate to their own datapath.
  function automatic logic [MAX_DATA_WIDTH-1:0] expand_imm(input logic [11:0] src2,
                                                           input int width);
    logic [MAX_DATA_WIDTH-1:0] base;
    logic [MAX_DATA_WIDTH-1:0] rotated;
    logic [MAX_DATA_WIDTH-1:0] mask;
    int rot;
    base = {{(MAX_DATA_WIDTH-8){1'b0}}, src2[7:0]};
    rot  = 2 * int'(src2[11:8]);
    if (rot == 0) rotated = base;
    else          rotated = (base >> rot) | (base << (width - rot));
    if (width >= MAX_DATA_WIDTH) mask = '1;
    else mask = (MAX_DATA_WIDTH'(1) << width) - MAX_DATA_WIDTH'(1);
    return rotated & mask;
  endfunction

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Bus bundle around the decode stage: fetch-side handshake, flush,
// write-back port and the issue packet towards execute.
//   master - the surrounding pipeline (drives fetch/WB/flush, accepts packets)
//   slave  - the decode stage
interface decode_pipe_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [31:0]           instruction;
  logic [DATA_WIDTH-1:0] pc;
  logic                  flush;
  logic                  wb_write_en;
  logic [ADDR_WIDTH-1:0] wb_address;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [DATA_WIDTH-1:0] operand1;
  logic [DATA_WIDTH-1:0] operand2;
  logic [DATA_WIDTH-1:0] store_data;
  logic [2:0]            alu_opcode;
  logic [3:0]            cond;
  logic                  set_flags;
  logic                  reg_write_en;
  logic [ADDR_WIDTH-1:0] dest;
  logic                  mem_write_en;
  logic                  mem_to_reg;
  logic                  branch;

  modport master (
    output fetch_valid, instruction, pc, flush, wb_write_en, wb_address, wb_data, issue_ready,
    input  fetch_ready, issue_valid, operand1, operand2, store_data, alu_opcode, cond,
           set_flags, reg_write_en, dest, mem_write_en, mem_to_reg, branch
  );

  modport slave (
    input  fetch_valid, instruction, pc, flush, wb_write_en, wb_address, wb_data, issue_ready,
    output fetch_ready, issue_valid, operand1, operand2, store_data, alu_opcode, cond,
           set_flags, reg_write_en, dest, mem_write_en, mem_to_reg, branch
  );
endinterface

// File: rtl/regfile_bypass.sv
// Architectural register file with write-back bypass.
//   clk, reset       - clock; async active-high reset clears every register
//   pc               - address of the instruction being decoded
//   rd_addr/rd_data  - NUM_READ asynchronous read ports
//   wr_en/addr/data  - synchronous write port (writes to R15 are dropped)
// Reads of R15 return pc+8; a read that matches the write in flight returns
// the write data so decode sees the value in the same cycle.
module regfile_bypass
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int NUM_READ   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] rd_addr [NUM_READ],
  output logic [DATA_WIDTH-1:0] rd_data [NUM_READ],
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);
  localparam logic [ADDR_WIDTH-1:0] PC_IDX = ADDR_WIDTH'(PC_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] pc_plus8;

  assign pc_plus8 = pc + DATA_WIDTH'(8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != PC_IDX)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
    assign rd_data[gi] = (rd_addr[gi] == PC_IDX)                ? pc_plus8 :
                         (wr_en && (wr_addr == rd_addr[gi]))    ? wr_data  :
                                                                  regs[rd_addr[gi]];
  end
endmodule

// File: rtl/decode_pipe_stage.sv
// ARMv7-subset decode stage between fetch and execute.
//   clk, reset - clock; async active-high reset returns everything to idle
//   bus        - slave side of decode_pipe_stage_if: fetch handshake,
//                flush, write-back port and the registered issue packet
// Decodes DP (AND/SUB/ADD/ORR/MOV/CMP), LDR/STR with imm12 and B; reads
// operands through regfile_bypass; inserts one bubble on a load-use hazard.
// DATA_WIDTH must not exceed decode_pkg::MAX_DATA_WIDTH.
module decode_pipe_stage
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input logic           clk,
  input logic           reset,
  decode_pipe_stage_if.slave bus
);
  logic [31:0]           instr;
  logic [5:0]            funct;
  logic [3:0]            cmd;
  logic [ADDR_WIDTH-1:0] rn_idx, rm_idx, rd_idx;
  logic [DATA_WIDTH-1:0] rn_val, rm_val, rd_val;
  logic [ADDR_WIDTH-1:0] rf_addr [3];
  logic [DATA_WIDTH-1:0] rf_data [3];

  issue_pkt_t            ctrl_next, ctrl_reg;
  logic [DATA_WIDTH-1:0] op1_next, op2_next, store_next;
  logic [DATA_WIDTH-1:0] op1_reg, op2_reg, store_reg;
  logic [ADDR_WIDTH-1:0] dest_next, dest_reg;
  logic                  dec_ok, uses_rn, uses_rm, uses_rd;

  // Destination of the LDR currently sitting in the output register.
  logic                  lu_valid_reg;
  logic [ADDR_WIDTH-1:0] lu_dest_reg;

  logic advance, ld_use, hazard, take;

  assign instr  = bus.instruction;
  assign funct  = instr[25:20];
  assign cmd    = funct[4:1];
  assign rn_idx = ADDR_WIDTH'(instr[19:16]);
  assign rd_idx = ADDR_WIDTH'(instr[15:12]);
  assign rm_idx = ADDR_WIDTH'(instr[3:0]);

  assign rf_addr[0] = rn_idx;
  assign rf_addr[1] = rm_idx;
  assign rf_addr[2] = rd_idx;
  assign rn_val     = rf_data[0];
  assign rm_val     = rf_data[1];
  assign rd_val     = rf_data[2];

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_READ(3)
  ) u_regfile (
    .clk(clk), .reset(reset), .pc(bus.pc),
    .rd_addr(rf_addr), .rd_data(rf_data),
    .wr_en(bus.wb_write_en), .wr_addr(bus.wb_address), .wr_data(bus.wb_data)
  );

  always_comb begin
    ctrl_next  = '0;
    op1_next   = '0;
    op2_next   = '0;
    store_next = '0;
    dest_next  = '0;
    dec_ok     = 1'b0;
    uses_rn    = 1'b0;
    uses_rm    = 1'b0;
    uses_rd    = 1'b0;
    ctrl_next.cond = instr[31:28];
    case (instr[27:26])
      OP_DP: begin
        dec_ok                 = 1'b1;
        uses_rn                = 1'b1;
        op1_next               = rn_val;
        dest_next              = rd_idx;
        ctrl_next.reg_write_en = 1'b1;
        ctrl_next.set_flags    = funct[0];
        if (funct[5]) begin
          op2_next = DATA_WIDTH'(expand_imm(instr[11:0], DATA_WIDTH));
        end else begin
          op2_next = rm_val;
          uses_rm  = 1'b1;
        end
        case (cmd)
          CMD_AND: ctrl_next.alu_op = ALU_AND;
          CMD_SUB: ctrl_next.alu_op = ALU_SUB;
          CMD_ADD: ctrl_next.alu_op = ALU_ADD;
          CMD_ORR: ctrl_next.alu_op = ALU_ORR;
          CMD_MOV: begin
            // MOV only passes Op2 through; Rn is not a true source.
            ctrl_next.alu_op = ALU_MOV;
            uses_rn          = 1'b0;
          end
          CMD_CMP: begin
            ctrl_next.alu_op       = ALU_SUB;
            ctrl_next.reg_write_en = 1'b0;
            ctrl_next.set_flags    = 1'b1;
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OP_MEM: begin
        dec_ok                 = 1'b1;
        uses_rn                = 1'b1;
        op1_next               = rn_val;
        op2_next               = DATA_WIDTH'(instr[11:0]);
        dest_next              = rd_idx;
        ctrl_next.alu_op       = funct[3] ? ALU_ADD : ALU_SUB;
        ctrl_next.mem_to_reg   = funct[0];
        ctrl_next.reg_write_en = funct[0];
        ctrl_next.mem_write_en = !funct[0];
        if (!funct[0]) begin
          store_next = rd_val;
          uses_rd    = 1'b1;
        end
      end
      OP_BR: begin
        dec_ok           = 1'b1;
        op1_next         = bus.pc + DATA_WIDTH'(8);
        // Signed cast sign-extends the word offset to the datapath width.
        op2_next         = DATA_WIDTH'($signed({instr[23:0], 2'b00}));
        ctrl_next.alu_op = ALU_ADD;
        ctrl_next.branch = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
    ctrl_next.valid = dec_ok;
  end

  // The output register may change when empty or when execute takes it.
  assign advance = !ctrl_reg.valid || bus.issue_ready;
  assign ld_use  = lu_valid_reg &&
                   ((uses_rn && (rn_idx == lu_dest_reg)) ||
                    (uses_rm && (rm_idx == lu_dest_reg)) ||
                    (uses_rd && (rd_idx == lu_dest_reg)));
  // Only when the LDR leaves this cycle would the consumer land directly
  // behind it; a bubble in between gives the load data time to return.
  assign hazard  = bus.fetch_valid && dec_ok && ld_use && ctrl_reg.valid && bus.issue_ready;
  assign take    = bus.fetch_valid && dec_ok && !hazard;

  // Flush accepts and drops whatever fetch is offering.
  assign bus.fetch_ready = !reset && (bus.flush || (advance && !hazard));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg     <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      store_reg    <= '0;
      dest_reg     <= '0;
      lu_valid_reg <= 1'b0;
      lu_dest_reg  <= '0;
    end else if (bus.flush || (advance && !take)) begin
      // Flush, bubble or undecodable input: hold an all-zero packet.
      ctrl_reg     <= '0;
      op1_reg      <= '0;
      op2_reg      <= '0;
      store_reg    <= '0;
      dest_reg     <= '0;
      lu_valid_reg <= 1'b0;
      lu_dest_reg  <= '0;
    end else if (advance) begin
      ctrl_reg     <= ctrl_next;
      op1_reg      <= op1_next;
      op2_reg      <= op2_next;
      store_reg    <= store_next;
      dest_reg     <= dest_next;
      lu_valid_reg <= ctrl_next.mem_to_reg;
      lu_dest_reg  <= dest_next;
    end
  end

  assign bus.issue_valid  = ctrl_reg.valid;
  assign bus.alu_opcode   = ctrl_reg.alu_op;
  assign bus.cond         = ctrl_reg.cond;
  assign bus.set_flags    = ctrl_reg.set_flags;
  assign bus.reg_write_en = ctrl_reg.reg_write_en;
  assign bus.mem_write_en = ctrl_reg.mem_write_en;
  assign bus.mem_to_reg   = ctrl_reg.mem_to_reg;
  assign bus.branch       = ctrl_reg.branch;
  assign bus.operand1     = op1_reg;
  assign bus.operand2     = op2_reg;
  assign bus.store_data   = store_reg;
  assign bus.dest         = dest_reg;
endmodule
